// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive byte deserializer.
package usb_rx_pkg;

   localparam int SYNC_LEN = 8;

   // Last eight bits of the SYNC field as seen in the window: seven zeros then a one
   localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 8'h80;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECEIVE = 2'd1,
      ERR     = 2'd2
   } rx_state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_STUFF   = 2'd1,
      ERR_PARTIAL = 2'd2
   } rx_err_t;

endpackage

// File: rtl/usb_rx_byte_deser_if.sv
// Bit-stream input and byte/status output bundle of the RX deserializer.
interface usb_rx_byte_deser_if #(
   parameter int BYTE_BITS = 8
);
   logic                 bit_strobe;
   logic                 d_orig;
   logic                 eop;
   logic [BYTE_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_active;
   logic                 rx_error;
   logic [1:0]           rx_err_code;

   // Line-side driver: supplies bits and end-of-packet, observes bytes and status
   modport master (
      output bit_strobe, d_orig, eop,
      input  rx_data, rx_valid, rx_active, rx_error, rx_err_code
   );

   // Deserializer side
   modport slave (
      input  bit_strobe, d_orig, eop,
      output rx_data, rx_valid, rx_active, rx_error, rx_err_code
   );
endinterface

// File: rtl/flex_stp_sr_rx.sv
// Serial-to-parallel shift register, resets and reloads to all ones.
// SHIFT_MSB=0: new bit enters at the MSB and the contents move right (LSB-first streams).
// SHIFT_MSB=1: new bit enters at the LSB and the contents move left.
module flex_stp_sr_rx #(
   parameter int NUM_BITS  = 8,
   parameter bit SHIFT_MSB = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_ones,
   input  logic                shift_enable,
   input  logic                serial_in,
   output logic [NUM_BITS-1:0] parallel_out
);

   logic [NUM_BITS-1:0] shift_reg;
   logic [NUM_BITS-1:0] shift_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BITS; gi++) begin : g_bit
         if (SHIFT_MSB) begin : g_left
            if (gi == 0) begin : g_in
               assign shift_next[gi] = serial_in;
            end else begin : g_mv
               assign shift_next[gi] = shift_reg[gi-1];
            end
         end else begin : g_right
            if (gi == NUM_BITS-1) begin : g_in
               assign shift_next[gi] = serial_in;
            end else begin : g_mv
               assign shift_next[gi] = shift_reg[gi+1];
            end
         end
      end
   endgenerate

   // Reload to all ones takes priority over a shift in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= '1;
      end else if (load_ones) begin
         shift_reg <= '1;
      end else if (shift_enable) begin
         shift_reg <= shift_next;
      end
   end

   assign parallel_out = shift_reg;

endmodule

// File: rtl/usb_rx_byte_deser.sv
// USB RX byte deserializer: SYNC hunt, bit-unstuffing, LSB-first byte assembly.
module usb_rx_byte_deser
   import usb_rx_pkg::*;
#(
   parameter int BYTE_BITS = 8,
   parameter int STUFF_LEN = 6
) (
   input  logic               clk,
   input  logic               rst,
   usb_rx_byte_deser_if.slave bus
);

   localparam int CNT_W  = $clog2(BYTE_BITS + 1);
   localparam int ONES_W = $clog2(STUFF_LEN + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(BYTE_BITS - 1);
   localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);
   localparam logic [ONES_W-1:0] ONES_ONE  = ONES_W'(1);

   rx_state_t            state_reg;
   logic [CNT_W-1:0]     bit_cnt_reg;
   logic [ONES_W-1:0]    ones_cnt_reg;
   logic [BYTE_BITS-1:0] rx_data_reg;
   logic                 rx_valid_reg;
   logic                 rx_active_reg;
   logic                 rx_error_reg;
   rx_err_t              rx_err_code_reg;

   logic [SYNC_LEN-1:0]  sync_win;
   logic [BYTE_BITS-1:0] data_sr;

   logic sync_match;
   logic stuff_hit;
   logic data_accept;
   logic win_reload;
   logic win_shift;

   // The match and the byte capture look at the value the shifters will hold after
   // this strobe, so the oldest bit of each register is shifted out unused.
   logic unused_bits;
   assign unused_bits = ^{sync_win[0], data_sr[0]};

   assign sync_match  = (state_reg == IDLE) && bus.bit_strobe &&
                        ({bus.d_orig, sync_win[SYNC_LEN-1:1]} == SYNC_PATTERN);
   assign stuff_hit   = (ones_cnt_reg == STUFF_MAX);
   assign data_accept = (state_reg == RECEIVE) && bus.bit_strobe && !bus.eop && !stuff_hit;

   // Window only hunts in IDLE; holding it at all ones elsewhere means every
   // return to IDLE starts from a clean window.
   assign win_reload = (state_reg != IDLE) || sync_match;
   assign win_shift  = (state_reg == IDLE) && bus.bit_strobe;

   flex_stp_sr_rx #(
      .NUM_BITS  (SYNC_LEN),
      .SHIFT_MSB (1'b0)
   ) u_sync_win (
      .clk          (clk),
      .rst          (rst),
      .load_ones    (win_reload),
      .shift_enable (win_shift),
      .serial_in    (bus.d_orig),
      .parallel_out (sync_win)
   );

   flex_stp_sr_rx #(
      .NUM_BITS  (BYTE_BITS),
      .SHIFT_MSB (1'b0)
   ) u_data_sr (
      .clk          (clk),
      .rst          (rst),
      .load_ones    (sync_match),
      .shift_enable (data_accept),
      .serial_in    (bus.d_orig),
      .parallel_out (data_sr)
   );

   // Packet FSM with counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         bit_cnt_reg     <= '0;
         ones_cnt_reg    <= '0;
         rx_data_reg     <= '0;
         rx_valid_reg    <= 1'b0;
         rx_active_reg   <= 1'b0;
         rx_error_reg    <= 1'b0;
         rx_err_code_reg <= ERR_NONE;
      end else begin
         rx_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (sync_match) begin
                  state_reg       <= RECEIVE;
                  rx_active_reg   <= 1'b1;
                  rx_error_reg    <= 1'b0;
                  rx_err_code_reg <= ERR_NONE;
                  bit_cnt_reg     <= '0;
                  // The final SYNC one already counts toward the stuffing run
                  ones_cnt_reg    <= ONES_ONE;
               end
            end
            RECEIVE: begin
               if (bus.eop) begin
                  state_reg     <= IDLE;
                  rx_active_reg <= 1'b0;
                  if (bit_cnt_reg != '0) begin
                     rx_error_reg    <= 1'b1;
                     rx_err_code_reg <= ERR_PARTIAL;
                  end
               end else if (bus.bit_strobe) begin
                  if (stuff_hit) begin
                     if (!bus.d_orig) begin
                        ones_cnt_reg <= '0;
                     end else begin
                        state_reg       <= ERR;
                        rx_error_reg    <= 1'b1;
                        rx_err_code_reg <= ERR_STUFF;
                     end
                  end else begin
                     ones_cnt_reg <= bus.d_orig ? ones_cnt_reg + 1'b1 : '0;
                     if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_reg  <= '0;
                        rx_data_reg  <= {bus.d_orig, data_sr[BYTE_BITS-1:1]};
                        rx_valid_reg <= 1'b1;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
               end
            end
            ERR: begin
               if (bus.eop) begin
                  state_reg     <= IDLE;
                  rx_active_reg <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.rx_data     = rx_data_reg;
   assign bus.rx_valid    = rx_valid_reg;
   assign bus.rx_active   = rx_active_reg;
   assign bus.rx_error    = rx_error_reg;
   assign bus.rx_err_code = rx_err_code_reg;

endmodule

// File: tb/tb_usb_rx_byte_deser.sv
// Directed bench for the USB RX byte deserializer.
module tb_usb_rx_byte_deser;

   logic clk;
   logic rst;

   usb_rx_byte_deser_if #(.BYTE_BITS(8)) bus ();

   usb_rx_byte_deser #(
      .BYTE_BITS (8),
      .STUFF_LEN (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   int         valid_cnt  = 0;
   int         consec_cnt = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] last_data  = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte monitor: one line per received byte
   always @(posedge clk) begin
      #1;
      if (bus.rx_valid === 1'b1) begin
         valid_cnt = valid_cnt + 1;
         last_data = bus.rx_data;
         if (prev_valid) consec_cnt = consec_cnt + 1;
         prev_valid = 1'b1;
         $display("rx byte 0x%02h at %0t", bus.rx_data, $time);
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic send_bit(input logic b);
      @(negedge clk);
      bus.bit_strobe = 1'b1;
      bus.d_orig     = b;
      @(negedge clk);
      bus.bit_strobe = 1'b0;
      bus.d_orig     = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic send_sync();
      for (int i = 0; i < 7; i++) send_bit(1'b0);
      send_bit(1'b1);
   endtask

   task automatic send_eop();
      @(negedge clk);
      bus.eop = 1'b1;
      @(negedge clk);
      bus.eop = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.bit_strobe = 1'b0;
      bus.d_orig     = 1'b0;
      bus.eop        = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.rx_data); end
      total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
      total++; if (bus.rx_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", bus.rx_active); end
      total++; if (bus.rx_error !== 1'b0 || bus.rx_err_code !== 2'd0) begin bad++; $display("FAIL reset_err: got %b/%0d want 0/0", bus.rx_error, bus.rx_err_code); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_clean_byte();
      int v0;
      v0 = valid_cnt;
      send_sync();
      total++; if (bus.rx_active !== 1'b1) begin bad++; $display("FAIL clean_active_rise: got %b want 1", bus.rx_active); end
      send_byte(8'hA5);
      total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL clean_valid_cnt: got %0d want 1", valid_cnt - v0); end
      total++; if (last_data !== 8'hA5) begin bad++; $display("FAIL clean_data: got %h want a5", last_data); end
      total++; if (bus.rx_data !== 8'hA5) begin bad++; $display("FAIL clean_data_held: got %h want a5", bus.rx_data); end
      send_eop();
      total++; if (bus.rx_active !== 1'b0) begin bad++; $display("FAIL clean_active_fall: got %b want 0", bus.rx_active); end
      total++; if (bus.rx_error !== 1'b0 || bus.rx_err_code !== 2'd0) begin bad++; $display("FAIL clean_err: got %b/%0d want 0/0", bus.rx_error, bus.rx_err_code); end
      $display("test_clean_byte done");
   endtask

   task automatic test_stuffing();
      int v0;
      v0 = valid_cnt;
      send_sync();
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      send_bit(1'b0);                       // stuffed zero, must be dropped
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      total++; if (last_data !== 8'hFF || valid_cnt - v0 !== 1) begin bad++; $display("FAIL stuff_first: got %h cnt %0d want ff cnt 1", last_data, valid_cnt - v0); end
      send_byte(8'h01);
      total++; if (last_data !== 8'h01) begin bad++; $display("FAIL stuff_second: got %h want 01", last_data); end
      send_eop();
      total++; if (valid_cnt - v0 !== 2) begin bad++; $display("FAIL stuff_valid_cnt: got %0d want 2", valid_cnt - v0); end
      total++; if (bus.rx_error !== 1'b0 || bus.rx_active !== 1'b0) begin bad++; $display("FAIL stuff_status: got err %b act %b want 0 0", bus.rx_error, bus.rx_active); end
      $display("test_stuffing done");
   endtask

   task automatic test_stuff_violation();
      int v0;
      v0 = valid_cnt;
      send_sync();
      for (int i = 0; i < 7; i++) send_bit(1'b1);
      total++; if (bus.rx_error !== 1'b1 || bus.rx_err_code !== 2'd1) begin bad++; $display("FAIL viol_err: got %b/%0d want 1/1", bus.rx_error, bus.rx_err_code); end
      total++; if (bus.rx_active !== 1'b1) begin bad++; $display("FAIL viol_active_held: got %b want 1", bus.rx_active); end
      send_byte(8'h00);                     // ignored while in error
      total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL viol_no_valid: got %0d want 0", valid_cnt - v0); end
      send_eop();
      total++; if (bus.rx_active !== 1'b0) begin bad++; $display("FAIL viol_active_fall: got %b want 0", bus.rx_active); end
      total++; if (bus.rx_error !== 1'b1 || bus.rx_err_code !== 2'd1) begin bad++; $display("FAIL viol_sticky: got %b/%0d want 1/1", bus.rx_error, bus.rx_err_code); end
      $display("test_stuff_violation done");
   endtask

   task automatic test_partial();
      int v0;
      v0 = valid_cnt;
      send_sync();
      total++; if (bus.rx_error !== 1'b0 || bus.rx_err_code !== 2'd0) begin bad++; $display("FAIL partial_err_clear: got %b/%0d want 0/0", bus.rx_error, bus.rx_err_code); end
      send_byte(8'h3C);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      send_eop();
      total++; if (valid_cnt - v0 !== 1 || last_data !== 8'h3C) begin bad++; $display("FAIL partial_byte: got %h cnt %0d want 3c cnt 1", last_data, valid_cnt - v0); end
      total++; if (bus.rx_error !== 1'b1 || bus.rx_err_code !== 2'd2) begin bad++; $display("FAIL partial_err: got %b/%0d want 1/2", bus.rx_error, bus.rx_err_code); end
      total++; if (bus.rx_active !== 1'b0) begin bad++; $display("FAIL partial_active: got %b want 0", bus.rx_active); end
      $display("test_partial done");
   endtask

   task automatic test_false_sync();
      int v0;
      v0 = valid_cnt;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      total++; if (bus.rx_active !== 1'b0) begin bad++; $display("FAIL noise_active: got %b want 0", bus.rx_active); end
      total++; if (bus.rx_error !== 1'b1 || bus.rx_err_code !== 2'd2) begin bad++; $display("FAIL noise_err_held: got %b/%0d want 1/2", bus.rx_error, bus.rx_err_code); end
      send_sync();
      total++; if (bus.rx_active !== 1'b1 || bus.rx_error !== 1'b0 || bus.rx_err_code !== 2'd0) begin bad++; $display("FAIL recover_sync: got act %b err %b/%0d want 1 0/0", bus.rx_active, bus.rx_error, bus.rx_err_code); end
      send_byte(8'h00);
      total++; if (valid_cnt - v0 !== 1 || last_data !== 8'h00) begin bad++; $display("FAIL recover_byte: got %h cnt %0d want 00 cnt 1", last_data, valid_cnt - v0); end
      send_eop();
      $display("test_false_sync done");
   endtask

   task automatic test_back_to_back();
      int v0;
      v0 = valid_cnt;
      send_sync();
      send_byte(8'h12);
      total++; if (last_data !== 8'h12) begin bad++; $display("FAIL b2b_first: got %h want 12", last_data); end
      send_byte(8'h34);
      // eop together with a strobe at a byte boundary: bit discarded, clean end
      @(negedge clk);
      bus.bit_strobe = 1'b1;
      bus.d_orig     = 1'b1;
      bus.eop        = 1'b1;
      @(negedge clk);
      bus.bit_strobe = 1'b0;
      bus.d_orig     = 1'b0;
      bus.eop        = 1'b0;
      @(negedge clk);
      total++; if (valid_cnt - v0 !== 2 || last_data !== 8'h34) begin bad++; $display("FAIL b2b_second: got %h cnt %0d want 34 cnt 2", last_data, valid_cnt - v0); end
      total++; if (bus.rx_active !== 1'b0 || bus.rx_error !== 1'b0) begin bad++; $display("FAIL b2b_eop_prio: got act %b err %b want 0 0", bus.rx_active, bus.rx_error); end
      send_eop();                           // eop in IDLE has no effect
      total++; if (bus.rx_active !== 1'b0 || bus.rx_error !== 1'b0) begin bad++; $display("FAIL idle_eop: got act %b err %b want 0 0", bus.rx_active, bus.rx_error); end
      total++; if (consec_cnt !== 0) begin bad++; $display("FAIL valid_width: got %0d consecutive want 0", consec_cnt); end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid();
      int v0;
      send_sync();
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      v0 = valid_cnt;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      total++; if (bus.rx_data !== 8'h00 || bus.rx_active !== 1'b0) begin bad++; $display("FAIL midrst_async: got %h act %b want 00 0", bus.rx_data, bus.rx_active); end
      total++; if (bus.rx_error !== 1'b0 || bus.rx_err_code !== 2'd0 || bus.rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_status: got err %b/%0d val %b want 0/0 0", bus.rx_error, bus.rx_err_code, bus.rx_valid); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL midrst_no_valid: got %0d want 0", valid_cnt - v0); end
      send_sync();
      send_byte(8'h5A);
      total++; if (valid_cnt - v0 !== 1 || last_data !== 8'h5A) begin bad++; $display("FAIL midrst_after: got %h cnt %0d want 5a cnt 1", last_data, valid_cnt - v0); end
      send_eop();
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_clean_byte();
      test_stuffing();
      test_stuff_violation();
      test_partial();
      test_false_sync();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/usb_rx_byte_deser.md
Name: usb_rx_byte_deser

Overview:
- Receive-side counterpart of the TX parallel-to-serial path.
- Takes the NRZI-decoded USB bit stream, one bit per strobe.
- Hunts for SYNC, strips stuffed bits, and assembles LSB-first bytes.
- Presents bytes with a one-cycle valid pulse plus packet-active and error status to the RX packet decoder.

Parameters:
- BYTE_BITS, 8, data bits per assembled byte.
- STUFF_LEN, 6, consecutive ones after which the next bit must be a stuffed zero.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_strobe  input  1  one-cycle pulse per received bit period; d_orig is valid while high.
- d_orig  input  1  NRZI-decoded data bit.
- eop  input  1  SE0 end-of-packet detected, level, sampled every cycle.
- rx_data  output  BYTE_BITS  last assembled byte; held until the next byte completes.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_active  output  1  high from SYNC match until packet end or error recovery.
- rx_error  output  1  sticky error flag; cleared on next SYNC match.
- rx_err_code  output  2  cause: 0 none, 1 stuff violation, 2 partial byte at EOP, 3 reserved.

Behaviour:
- Reset values (async, immediate):
  - rx_data=0x00, rx_valid=0, rx_active=0, rx_error=0, rx_err_code=0.
  - State=IDLE, shift register all ones, bit_cnt=0, ones_cnt=0.
- States: IDLE, RECEIVE, ERR.
- Bit order: LSB-first. Each accepted bit enters at the MSB and shifts right, so after 8 accepted bits, register[0] holds the first bit.
- IDLE:
  - Each bit_strobe shifts d_orig into the 8-bit window.
  - Window == 8'h80 (bits received 0,0,0,0,0,0,0,1) -> RECEIVE.
  - On entry to RECEIVE: rx_active=1; rx_error=0, rx_err_code=0; bit_cnt=0; ones_cnt=1 (the trailing SYNC one counts toward stuffing); data register reloaded to all ones.
  - eop in IDLE is ignored.
- RECEIVE, on bit_strobe without eop:
  - ones_cnt == STUFF_LEN and d_orig=0: bit dropped, ones_cnt=0, bit_cnt unchanged.
  - ones_cnt == STUFF_LEN and d_orig=1: rx_error=1, rx_err_code=1 -> ERR. rx_active stays high.
  - Otherwise: bit shifted in, bit_cnt+1, ones_cnt = d_orig ? ones_cnt+1 : 0.
  - bit_cnt reaching BYTE_BITS: rx_data is loaded with the completed byte and rx_valid pulses for one cycle on the clock edge after the strobe carrying the 8th data bit. bit_cnt wraps to 0.
- RECEIVE, eop high (takes priority over a simultaneous bit_strobe; that bit is discarded):
  - bit_cnt == 0: clean end; rx_active=0 next cycle -> IDLE.
  - bit_cnt != 0: rx_error=1, rx_err_code=2, rx_active=0 -> IDLE. Partial byte is never presented.
- ERR:
  - All bits ignored; no rx_valid.
  - On eop: rx_active=0 -> IDLE. rx_error and rx_err_code are held.
- Every entry to IDLE reloads the SYNC window to all ones, so no stale bits create a false SYNC match.
- rx_valid never asserts in IDLE or ERR, and never on two consecutive cycles.
- Reset mid-packet: all outputs return to reset values immediately; no rx_valid is produced.

Decomposition:
- Package usb_rx_pkg:
  - rx_state_t enum (IDLE, RECEIVE, ERR).
  - rx_err_t enum (ERR_NONE, ERR_STUFF, ERR_PARTIAL).
  - Constant SYNC_PATTERN = 8'h80.
- Sub-module flex_stp_sr_rx, serial-to-parallel flex shift register:
  - Parameters NUM_BITS and SHIFT_MSB; active-high async reset to all ones; shift_enable; serial_in; parallel_out.
  - One instance (SHIFT_MSB=0) is the data register.
  - The SYNC window uses a second instance.
- Top module holds the FSM, bit_cnt, ones_cnt and output registers.

Test Plan:
- Clean byte: SYNC then bits of 0xA5 LSB-first, then eop -> rx_active rises after SYNC; one rx_valid with rx_data=0xA5; rx_active falls; rx_error=0.
- Stuffing: SYNC then 0xFF, with a stuffed 0 after the 5th data one (ones_cnt reaches 6 with the SYNC one), then 0x01 and eop -> rx_data 0xFF then 0x01; exactly 2 rx_valid pulses.
- Stuff violation: SYNC then 7 ones -> rx_error=1, rx_err_code=1; no rx_valid; rx_active drops only at eop.
- Partial byte: SYNC, 0x3C, then 4 bits and eop -> rx_valid once (0x3C); rx_error=1, rx_err_code=2.
- False SYNC and recovery: noise 1,0,1,1 then valid SYNC and 0x00 -> no match during noise; rx_data=0x00 valid; earlier sticky error cleared at the SYNC match.
- Reset mid-byte: assert rst after 4 data bits -> all outputs 0 at once; next SYNC plus 0x5A gives rx_data=0x5A.
